// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for the pipeline hazard controller
package pipe_pkg;

  localparam int         MD_LAT_DEF = 32;
  localparam int         PERF_W_DEF = 32;
  localparam logic [4:0] REG_ZERO   = 5'd0;

  typedef enum logic [1:0] {
    ACT_RESET,
    ACT_REDIRECT,
    ACT_STALL,
    ACT_RUN
  } hz_action_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic id_flush;
  } hz_ctl_t;

  // Pipeline-register control word for each hazard decision.
  function automatic hz_ctl_t action_ctl(input hz_action_e act);
    hz_ctl_t ctl;
    ctl = '{pc_write: 1'b1, if_id_write: 1'b1, if_flush: 1'b0, id_flush: 1'b0};
    case (act)
      ACT_RESET:    ctl = '{pc_write: 1'b0, if_id_write: 1'b0, if_flush: 1'b1, id_flush: 1'b1};
      ACT_REDIRECT: ctl = '{pc_write: 1'b1, if_id_write: 1'b1, if_flush: 1'b1, id_flush: 1'b1};
      ACT_STALL:    ctl = '{pc_write: 1'b0, if_id_write: 1'b0, if_flush: 1'b0, id_flush: 1'b1};
      ACT_RUN:      ctl = '{pc_write: 1'b1, if_id_write: 1'b1, if_flush: 1'b0, id_flush: 1'b0};
      default:      ctl = '{pc_write: 1'b1, if_id_write: 1'b1, if_flush: 1'b0, id_flush: 1'b0};
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID/EX hazard inputs and pipeline-control outputs
interface hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  logic [4:0]        ID_Rs;
  logic [4:0]        ID_Rt;
  logic              ID_Rt_used;
  logic              ID_MD_op;
  logic              ID_HiLo_rd;
  logic              EX_MemtoReg;
  logic [4:0]        EX_WR_out;
  logic              EX_PCSrc;
  logic              EX_Jump;
  logic              EX_Jr_Jalr;
  logic              EX_MD_start;
  logic              PC_Write;
  logic              IF_ID_Write;
  logic              IF_Flush;
  logic              ID_Flush;
  logic              md_busy;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_events;

  modport master (
    output ID_Rs, ID_Rt, ID_Rt_used, ID_MD_op, ID_HiLo_rd,
    output EX_MemtoReg, EX_WR_out, EX_PCSrc, EX_Jump, EX_Jr_Jalr, EX_MD_start,
    input  PC_Write, IF_ID_Write, IF_Flush, ID_Flush, md_busy, stall_cycles, flush_events
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_Rt_used, ID_MD_op, ID_HiLo_rd,
    input  EX_MemtoReg, EX_WR_out, EX_PCSrc, EX_Jump, EX_Jr_Jalr, EX_MD_start,
    output PC_Write, IF_ID_Write, IF_Flush, ID_Flush, md_busy, stall_cycles, flush_events
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with sync active-low clear, falling-edge
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_clr_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(negedge i_clk) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - advance/stall/flush decision for IF/ID and ID/EX, plus mult/div busy tracking
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = 6,
  parameter int PERF_W = PERF_W_DEF
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  logic [CNT_W-1:0] r_md_cnt;
  logic             w_md_busy;
  logic             w_redirect;
  logic             w_load_use;
  logic             w_md_stall;
  hz_action_e       w_action;
  hz_ctl_t          w_ctl;

  assign w_md_busy  = (r_md_cnt != '0);
  assign w_redirect = hz.EX_PCSrc | hz.EX_Jump | hz.EX_Jr_Jalr;
  assign w_load_use = hz.EX_MemtoReg & (hz.EX_WR_out != REG_ZERO) &
                      ((hz.EX_WR_out == hz.ID_Rs) |
                       (hz.ID_Rt_used & (hz.EX_WR_out == hz.ID_Rt)));
  assign w_md_stall = w_md_busy & (hz.ID_HiLo_rd | hz.ID_MD_op);

  // A redirect squashes the stalled ID instruction, so it outranks both stall sources.
  always_comb begin
    w_action = ACT_RUN;
    if (!rst) begin
      w_action = ACT_RESET;
    end else if (w_redirect) begin
      w_action = ACT_REDIRECT;
    end else if (w_load_use || w_md_stall) begin
      w_action = ACT_STALL;
    end
  end

  assign w_ctl          = action_ctl(w_action);
  assign hz.PC_Write    = w_ctl.pc_write;
  assign hz.IF_ID_Write = w_ctl.if_id_write;
  assign hz.IF_Flush    = w_ctl.if_flush;
  assign hz.ID_Flush    = w_ctl.id_flush;
  assign hz.md_busy     = w_md_busy;

  // A new issue always restarts the window, even over an in-flight operation.
  always_ff @(negedge clk) begin
    if (!rst) begin
      r_md_cnt <= '0;
    end else if (hz.EX_MD_start) begin
      r_md_cnt <= CNT_W'(MD_LAT);
    end else if (w_md_busy) begin
      r_md_cnt <= r_md_cnt - CNT_W'(1);
    end
  end

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .i_clk   (clk),
    .i_clr_n (rst),
    .i_inc   (~w_ctl.pc_write),
    .o_count (hz.stall_cycles)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .i_clk   (clk),
    .i_clr_n (rst),
    .i_inc   (w_redirect),
    .o_count (hz.flush_events)
  );

endmodule
